// File: rtl/transmisor.sv
// 1000BASE-X PCS transmit path: ordered-set state machine feeding an 8b/10b
// encoder with running disparity; one registered code-group per GTX_CLK.
module transmisor (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] tx_code_group
);

    typedef enum logic [2:0] {
        IDLE_K, IDLE_D, START, DATA, END_T, END_R, EXT_R
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    state_t      state;
    state_t      next_state;
    logic        tx_even;
    logic        rd_pos;
    logic        sym_k;
    logic [7:0]  sym_oct;

    logic [4:0]  blk5;
    logic [2:0]  blk3;
    logic [5:0]  code6_m;
    logic [5:0]  code6;
    logic [3:0]  code4_m;
    logic [3:0]  code4;
    logic        rd_mid;
    logic        rd_end;
    logic        alt7;
    int          ones6;
    int          ones4;

    // RD- column of the 5b/6b table (abcdei, a in the MSB)
    function automatic logic [5:0] six_rdm(input logic [4:0] x);
        case (x)
            5'd0:    return 6'b100111;
            5'd1:    return 6'b011101;
            5'd2:    return 6'b101101;
            5'd3:    return 6'b110001;
            5'd4:    return 6'b110101;
            5'd5:    return 6'b101001;
            5'd6:    return 6'b011001;
            5'd7:    return 6'b111000;
            5'd8:    return 6'b111001;
            5'd9:    return 6'b100101;
            5'd10:   return 6'b010101;
            5'd11:   return 6'b110100;
            5'd12:   return 6'b001101;
            5'd13:   return 6'b101100;
            5'd14:   return 6'b011100;
            5'd15:   return 6'b010111;
            5'd16:   return 6'b011011;
            5'd17:   return 6'b100011;
            5'd18:   return 6'b010011;
            5'd19:   return 6'b110010;
            5'd20:   return 6'b001011;
            5'd21:   return 6'b101010;
            5'd22:   return 6'b011010;
            5'd23:   return 6'b111010;
            5'd24:   return 6'b110011;
            5'd25:   return 6'b100110;
            5'd26:   return 6'b010110;
            5'd27:   return 6'b110110;
            5'd28:   return 6'b001110;
            5'd29:   return 6'b101110;
            5'd30:   return 6'b011110;
            default: return 6'b101011;
        endcase
    endfunction

    // RD- column of the 3b/4b table (fghj); y=7 is resolved by the caller
    function automatic logic [3:0] four_rdm(input logic [2:0] y);
        case (y)
            3'd0:    return 4'b1011;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b1100;
            3'd4:    return 4'b1101;
            3'd5:    return 4'b1010;
            3'd6:    return 4'b0110;
            default: return 4'b1110;
        endcase
    endfunction

    always_ff @(posedge GTX_CLK) begin
        if (!RESET) begin
            state         <= IDLE_K;
            rd_pos        <= 1'b0;
            tx_even       <= 1'b1;
            tx_code_group <= 10'h000;
        end else begin
            state         <= next_state;
            rd_pos        <= rd_end;
            tx_even       <= ~tx_even;
            tx_code_group <= {code6, code4};
        end
    end

    // Ordered-set selection: IDLE_K, START and idle re-entry always fall on even slots
    always_comb begin
        next_state = state;
        sym_k      = 1'b1;
        sym_oct    = K28_5;
        case (state)
            IDLE_K: begin
                if (TX_EN) begin
                    sym_oct    = K27_7;
                    next_state = DATA;
                end else begin
                    next_state = IDLE_D;
                end
            end
            IDLE_D: begin
                sym_k      = 1'b0;
                sym_oct    = rd_pos ? D16_2 : D5_6;
                next_state = TX_EN ? START : IDLE_K;
            end
            START: begin
                sym_oct    = K27_7;
                next_state = DATA;
            end
            DATA: begin
                if (!TX_EN) begin
                    sym_oct    = K29_7;
                    next_state = END_T;
                end else if (TX_ER) begin
                    sym_oct = K30_7;
                end else begin
                    sym_k   = 1'b0;
                    sym_oct = TXD;
                end
            end
            END_T: begin
                sym_oct    = K23_7;
                next_state = tx_even ? EXT_R : IDLE_K;
            end
            END_R, EXT_R: begin
                sym_oct    = K23_7;
                next_state = IDLE_K;
            end
            default: next_state = IDLE_K;
        endcase
    end

    always_comb begin
        blk5    = sym_oct[4:0];
        blk3    = sym_oct[7:5];
        code6_m = (sym_k && blk5 == 5'd28) ? 6'b001111 : six_rdm(blk5);
        ones6   = $countones(code6_m);
        code6   = (rd_pos && (ones6 != 3 || code6_m == 6'b111000)) ? ~code6_m : code6_m;

        if ($countones(code6) > 3 || code6 == 6'b000111) begin
            rd_mid = 1'b1;
        end else if ($countones(code6) < 3 || code6 == 6'b111000) begin
            rd_mid = 1'b0;
        end else begin
            rd_mid = rd_pos;
        end

        // A7 avoids a run of five equal bits across the sub-block boundary
        alt7 = sym_k ||
               (!rd_mid && (blk5 inside {5'd17, 5'd18, 5'd20})) ||
               ( rd_mid && (blk5 inside {5'd11, 5'd13, 5'd14}));
        code4_m = (blk3 == 3'd7) ? (alt7 ? 4'b0111 : 4'b1110) : four_rdm(blk3);
        ones4   = $countones(code4_m);

        if (sym_k && blk5 == 5'd28 && (blk3 inside {3'd1, 3'd2, 3'd5, 3'd6})) begin
            code4 = rd_mid ? code4_m : ~code4_m;
        end else if (rd_mid && (ones4 != 2 || code4_m == 4'b1100)) begin
            code4 = ~code4_m;
        end else begin
            code4 = code4_m;
        end

        if ($countones(code4) > 2 || code4 == 4'b0011) begin
            rd_end = 1'b1;
        end else if ($countones(code4) < 2 || code4 == 4'b1100) begin
            rd_end = 1'b0;
        end else begin
            rd_end = rd_mid;
        end
    end

endmodule

// File: tb/tb_transmisor.sv
// Self-checking bench for transmisor: directed ordered-set sequences plus random
// packets compared against a frame-level reference model with its own 8b/10b tables.
`timescale 1ns/1ps
module tb_transmisor;

    logic       GTX_CLK = 1'b0;
    logic       RESET   = 1'b0;
    logic [7:0] TXD     = 8'h00;
    logic       TX_EN   = 1'b0;
    logic       TX_ER   = 1'b0;
    logic [9:0] tx_code_group;

    int checks = 0;
    int errors = 0;

    localparam int KD = 0, KK = 1, KS = 2, KT = 3, KR = 4, KV = 5, KI = 6;

    logic       m_rd;
    logic       st_en   [512];
    logic       st_er   [512];
    logic [7:0] st_d    [512];
    int         st_kind [512];
    int         st_n;

    transmisor dut (
        .GTX_CLK       (GTX_CLK),
        .RESET         (RESET),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .tx_code_group (tx_code_group)
    );

    always #4 GTX_CLK = ~GTX_CLK;

    // Both columns written out: {RD-, RD+}
    function automatic logic [11:0] six_tab(input int x);
        case (x)
            0:  return {6'b100111, 6'b011000};
            1:  return {6'b011101, 6'b100010};
            2:  return {6'b101101, 6'b010010};
            3:  return {6'b110001, 6'b110001};
            4:  return {6'b110101, 6'b001010};
            5:  return {6'b101001, 6'b101001};
            6:  return {6'b011001, 6'b011001};
            7:  return {6'b111000, 6'b000111};
            8:  return {6'b111001, 6'b000110};
            9:  return {6'b100101, 6'b100101};
            10: return {6'b010101, 6'b010101};
            11: return {6'b110100, 6'b110100};
            12: return {6'b001101, 6'b001101};
            13: return {6'b101100, 6'b101100};
            14: return {6'b011100, 6'b011100};
            15: return {6'b010111, 6'b101000};
            16: return {6'b011011, 6'b100100};
            17: return {6'b100011, 6'b100011};
            18: return {6'b010011, 6'b010011};
            19: return {6'b110010, 6'b110010};
            20: return {6'b001011, 6'b001011};
            21: return {6'b101010, 6'b101010};
            22: return {6'b011010, 6'b011010};
            23: return {6'b111010, 6'b000101};
            24: return {6'b110011, 6'b001100};
            25: return {6'b100110, 6'b100110};
            26: return {6'b010110, 6'b010110};
            27: return {6'b110110, 6'b001001};
            28: return {6'b001110, 6'b001110};
            29: return {6'b101110, 6'b010001};
            30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    function automatic logic [7:0] four_tab(input int y);
        case (y)
            0: return {4'b1011, 4'b0100};
            1: return {4'b1001, 4'b1001};
            2: return {4'b0101, 4'b0101};
            3: return {4'b1100, 4'b0011};
            4: return {4'b1101, 4'b0010};
            5: return {4'b1010, 4'b1010};
            6: return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    function automatic logic [9:0] enc_data(input logic [7:0] b);
        int         x;
        int         y;
        logic [11:0] s;
        logic [5:0] s6;
        logic       mid;
        logic [7:0] f;
        x   = int'(b[4:0]);
        y   = int'(b[7:5]);
        s   = six_tab(x);
        s6  = m_rd ? s[5:0] : s[11:6];
        mid = ($countones(s6) == 3) ? m_rd : ~m_rd;
        if (y == 7 && ((!mid && (x == 17 || x == 18 || x == 20)) ||
                       ( mid && (x == 11 || x == 13 || x == 14))))
            f = 8'b0111_1000;
        else
            f = four_tab(y);
        return {s6, (mid ? f[3:0] : f[7:4])};
    endfunction

    // Emits one code-group and advances the model RD from the whole group's balance
    function automatic logic [9:0] model_code(input int kind, input logic [7:0] oct);
        logic [9:0] c;
        case (kind)
            KK: c = m_rd ? 10'h305 : 10'h0FA;
            KS: c = m_rd ? 10'h097 : 10'h368;
            KT: c = m_rd ? 10'h117 : 10'h2E8;
            KR: c = m_rd ? 10'h057 : 10'h3A8;
            KV: c = m_rd ? 10'h217 : 10'h1E8;
            KI: c = m_rd ? enc_data(8'h50) : enc_data(8'hC5);
            default: c = enc_data(oct);
        endcase
        if ($countones(c) > 5) m_rd = 1'b1;
        else if ($countones(c) < 5) m_rd = 1'b0;
        return c;
    endfunction

    // Frame-level expectation: slot 0 is the even slot right after reset release
    task automatic plan();
        int i;
        int e;
        int k;
        i = 0;
        while (i < st_n) begin
            if (!st_en[i]) begin
                st_kind[i] = (i % 2 == 0) ? KK : KI;
                i++;
            end else begin
                e = i + 1;
                while (e < st_n && st_en[e]) e++;
                k = i;
                if (k % 2 == 1) begin
                    st_kind[k] = KI;
                    k++;
                end
                st_kind[k] = KS;
                k++;
                while (k < e) begin
                    st_kind[k] = st_er[k] ? KV : KD;
                    k++;
                end
                st_kind[e]     = KT;
                st_kind[e + 1] = KR;
                k = e + 2;
                if (k % 2 == 1) begin
                    st_kind[k] = KR;
                    k++;
                end
                i = k;
            end
        end
    endtask

    task automatic drive(input logic en, input logic er, input logic [7:0] d,
                         output logic [9:0] got);
        TX_EN = en;
        TX_ER = er;
        TXD   = d;
        @(posedge GTX_CLK);
        #1;
        got = tx_code_group;
    endtask

    task automatic do_reset();
        logic [9:0] got;
        RESET = 1'b0;
        drive(1'b0, 1'b0, 8'h00, got);
        drive(1'b0, 1'b0, 8'h00, got);
        RESET = 1'b1;
        m_rd  = 1'b0;
    endtask

    task automatic gen_random(input int npk);
        int n;
        int gap;
        int len;
        n   = 0;
        gap = 1 + int'($urandom_range(0, 4));
        for (int g = 0; g < gap; g++) begin
            st_en[n] = 1'b0; st_er[n] = 1'($urandom_range(0, 1)); st_d[n] = 8'($urandom); n++;
        end
        for (int p = 0; p < npk; p++) begin
            len = 2 + int'($urandom_range(0, 10));
            for (int b = 0; b < len; b++) begin
                st_en[n] = 1'b1; st_er[n] = ($urandom_range(0, 7) == 0); st_d[n] = 8'($urandom); n++;
            end
            gap = (p == npk - 1) ? 6 : 3 + int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                st_en[n] = 1'b0; st_er[n] = 1'($urandom_range(0, 1)); st_d[n] = 8'($urandom); n++;
            end
        end
        st_n = n;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        logic [9:0] exp_a [6] = '{10'h0FA, 10'h245, 10'h0FA, 10'h245, 10'h0FA, 10'h245};
        RESET = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b1, 8'hA5, got);
            checks++;
            if (got !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h expected %h", j, got, 10'h000);
            end
        end
        RESET = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, (j == 2 || j == 3), 8'h00, got);
            checks++;
            if (got !== exp_a[j]) begin
                errors++;
                $display("FAIL idle_seq[%0d] got %h expected %h", j, got, exp_a[j]);
            end
        end
    endtask

    task automatic test_even_start();
        logic [9:0] got;
        logic [7:0] d;
        logic [9:0] exp_a [18] = '{10'h0FA, 10'h245, 10'h0FA, 10'h245, 10'h368,
                                   10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5,
                                   10'h2A6, 10'h274, 10'h2E8, 10'h3A8, 10'h0FA, 10'h245};
        do_reset();
        for (int j = 0; j < 18; j++) begin
            d = (j < 12) ? 8'h55 : (j == 12) ? 8'hD5 : 8'h00;
            drive((j >= 4 && j < 14), 1'b0, d, got);
            checks++;
            if (got !== exp_a[j]) begin
                errors++;
                $display("FAIL even_start[%0d] got %h expected %h", j, got, exp_a[j]);
            end
        end
    endtask

    task automatic test_term_odd();
        logic [9:0] got;
        logic [9:0] exp_a [9] = '{10'h0FA, 10'h245, 10'h368, 10'h274, 10'h274,
                                  10'h2E8, 10'h3A8, 10'h3A8, 10'h0FA};
        do_reset();
        for (int j = 0; j < 9; j++) begin
            drive((j >= 2 && j < 5), 1'b0, 8'h00, got);
            checks++;
            if (got !== exp_a[j]) begin
                errors++;
                $display("FAIL term_odd[%0d] got %h expected %h", j, got, exp_a[j]);
            end
        end
    endtask

    task automatic test_odd_start();
        logic [9:0] got;
        logic [7:0] d_a   [8] = '{8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [9:0] exp_a [8] = '{10'h0FA, 10'h245, 10'h368, 10'h274,
                                  10'h2E8, 10'h3A8, 10'h0FA, 10'h245};
        do_reset();
        for (int j = 0; j < 8; j++) begin
            drive((j >= 1 && j < 4), 1'b0, d_a[j], got);
            checks++;
            if (got !== exp_a[j]) begin
                errors++;
                $display("FAIL odd_start[%0d] got %h expected %h", j, got, exp_a[j]);
            end
        end
    endtask

    task automatic test_error();
        logic [9:0] got;
        logic [7:0] d_a   [12] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [9:0] exp_n [9]  = '{10'h0FA, 10'h245, 10'h368, 10'h274, 10'h1E8,
                                   10'h274, 10'h2E8, 10'h3A8, 10'h0FA};
        logic [9:0] exp_p [12] = '{10'h0FA, 10'h245, 10'h368, 10'h31B, 10'h217, 10'h18B,
                                   10'h117, 10'h057, 10'h305, 10'h296, 10'h0FA, 10'h245};
        do_reset();
        for (int j = 0; j < 9; j++) begin
            drive((j >= 2 && j < 6), (j == 4), 8'h00, got);
            checks++;
            if (got !== exp_n[j]) begin
                errors++;
                $display("FAIL err_rdneg[%0d] got %h expected %h", j, got, exp_n[j]);
            end
        end
        do_reset();
        for (int j = 0; j < 12; j++) begin
            drive((j >= 2 && j < 6), (j == 4), d_a[j], got);
            checks++;
            if (got !== exp_p[j]) begin
                errors++;
                $display("FAIL err_rdpos[%0d] got %h expected %h", j, got, exp_p[j]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [9:0] got;
        logic [9:0] exp_a [3] = '{10'h0FA, 10'h245, 10'h0FA};
        do_reset();
        drive(1'b0, 1'b0, 8'h00, got);
        drive(1'b0, 1'b0, 8'h00, got);
        drive(1'b1, 1'b0, 8'h12, got);
        checks++;
        if (got !== 10'h368) begin
            errors++;
            $display("FAIL rst_mid_start got %h expected %h", got, 10'h368);
        end
        drive(1'b1, 1'b0, 8'h00, got);
        RESET = 1'b0;
        drive(1'b1, 1'b0, 8'h00, got);
        checks++;
        if (got !== 10'h000) begin
            errors++;
            $display("FAIL rst_mid_abort got %h expected %h", got, 10'h000);
        end
        RESET = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b0, 8'h00, got);
            checks++;
            if (got !== exp_a[j]) begin
                errors++;
                $display("FAIL rst_mid_idle[%0d] got %h expected %h", j, got, exp_a[j]);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] got;
        logic [9:0] exp;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            gen_random(4);
            plan();
            for (int j = 0; j < st_n; j++) begin
                drive(st_en[j], st_er[j], st_d[j], got);
                exp = model_code(st_kind[j], st_d[j]);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random r%0d cyc %0d en %b er %b d %h got %h expected %h",
                             r, j, st_en[j], st_er[j], st_d[j], got, exp);
                end
            end
        end
    endtask

    initial begin
        m_rd = 1'b0;
        st_n = 0;
        test_reset();
        test_even_start();
        test_term_odd();
        test_odd_start();
        test_error();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transmisor.md
TRANSMISOR -- requirements
Module: transmisor

Interface
REQ-001 GTX_CLK  input  1  Single clock; all state updates on its rising edge.
REQ-002 RESET  input  1  Synchronous, active-low reset, sampled on the GTX_CLK rising edge.
REQ-003 TXD  input  8  GMII transmit octet, bit 7 = H, bit 0 = A.
REQ-004 TX_EN  input  1  GMII transmit enable; high marks a packet octet.
REQ-005 TX_ER  input  1  GMII transmit error; meaningful only while TX_EN is high.
REQ-006 tx_code_group  output  10  Registered 8b/10b code-group; bit 9 = a … bit 4 = i, bit 3 = f … bit 0 = j.
REQ-007 The block has no parameters.

Function
REQ-008 The block is an 1000BASE-X PCS transmit path: an ordered-set state machine followed by an 8b/10b encoder with running disparity (RD).
REQ-009 Latency: inputs sampled at edge n produce the code-group registered at edge n, held until edge n+1.
REQ-010 The block keeps a tx_even flag that toggles every clock; the K of an idle set, /S/ and idle re-entry occur only in even slots.
REQ-011 FSM states: IDLE_K, IDLE_D, START, DATA, END_T, END_R, EXT_R.
REQ-012 IDLE_K (even slot) emits K28.5 and goes to IDLE_D.
REQ-013 IDLE_D emits D16.2 (/I2/) if RD is positive after K28.5, else D5.6 (/I1/), restoring RD to negative. It then goes to IDLE_K.
REQ-014 If TX_EN is sampled high in an even slot while idle, the block emits /S/ (K27.7) in place of that octet and goes to DATA.
REQ-015 If TX_EN is sampled high in an odd slot, the block completes the idle D. It emits /S/ in the next (even) slot, replacing that cycle's octet; the first octet is dropped.
REQ-016 DATA, TX_EN=1, TX_ER=0: the block emits Dx.y encoding of TXD (x = TXD[4:0], y = TXD[7:5]).
REQ-017 DATA, TX_EN=1, TX_ER=1: the block emits /V/ (K30.7).
REQ-018 DATA, TX_EN=0: the block emits /T/ (K29.7) and goes to END_T. END_T emits /R/ (K23.7).
REQ-019 If the slot after the first /R/ is even, the block emits idle K28.5 there. If it is odd, the block emits a second /R/ (EXT_R) and then K28.5.
REQ-020 TX_ER with TX_EN=0 (carrier extension) is ignored; idle continues.
REQ-021 Encoding uses standard 5b/6b and 3b/4b tables. The block selects the RD- or RD+ column from the current RD.
REQ-022 RD updates after each sub-block: unbalanced sub-block flips RD; 000111/111000 and 0011/1100 are handled per IEEE 802.3 clause 36.
REQ-023 D.x.7 uses the alternate A7 (0111/1000) when (RD- and x ∈ {17,18,20}) or (RD+ and x ∈ {11,13,14}). K.x.7 always uses A7.
REQ-024 Required code values (RD-/RD+): K28.5 0x0FA/0x305; K27.7 0x368/0x097; K29.7 0x2E8/0x117; K23.7 0x3A8/0x057; K30.7 0x1E8/0x217; D16.2 RD+ 0x245; D0.0 0x274/0x18B; D21.2 0x2A5; D21.6 0x2A6.

Reset
REQ-025 While RESET=0 at an edge, tx_code_group <= 10'h000, FSM <= IDLE_K, RD <= negative, and tx_even <= even.
REQ-026 Reset mid-packet aborts immediately with no /T/ or /R/. The first edge after release emits K28.5 RD- (0x0FA).

Verification
REQ-027 Reset, then idle with TX_EN=0 → 0x000, then the repeating sequence 0x0FA, 0x245.
REQ-028 TX_EN rises in an even slot, with TXD=0x55 x8, then 0xD5, then 0x00 → /S/ 0x368, D21.2 0x2A5 x7, D21.6 0x2A6, D0.0 with the correct RD column.
REQ-029 TX_EN falls so /T/ lands in an even slot → /T/, one /R/, then 0x0FA. When /T/ lands in an odd slot → /T/, /R/, /R/, then 0x0FA.
REQ-030 TX_ER=1 for one cycle mid-packet → a single /V/ (0x1E8 or 0x217 per RD), and data resumes with RD continuous.
REQ-031 TX_EN rises in an odd slot → the idle D is completed, /S/ is emitted in the next even slot, and the first octet is dropped.
REQ-032 RESET asserted during DATA → 0x000 on the next edge; after release, 0x0FA, 0x245.
